// File: rtl/micro_sequencer.sv
// Hardwired fetch/execute micro-sequencer for the 8-bit accumulator CPU.
// Every control word is registered and held for HOLD_CYCLES clocks so the PC's alternating increment stays in step.
module micro_sequencer #(
    parameter int HOLD_CYCLES = 2,
    parameter int OPW         = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [OPW-1:0] ir_opcode,
    input  logic           acc_neg,
    output logic [15:0]    control_signals,
    output logic           busy,
    output logic           halted
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    // Control bit map shared by every datapath block
    localparam logic [15:0] C_MAR_PC   = 16'h0001;
    localparam logic [15:0] C_MBR_MEM  = 16'h0002;
    localparam logic [15:0] C_IR_MBR   = 16'h0004;
    localparam logic [15:0] C_MAR_MBR  = 16'h0008;
    localparam logic [15:0] C_PC_INC   = 16'h0010;
    localparam logic [15:0] C_MBR_ACC  = 16'h0020;
    localparam logic [15:0] C_MEM_MBR  = 16'h0040;
    localparam logic [15:0] C_BR_MBR   = 16'h0080;
    localparam logic [15:0] C_ACC_CLR  = 16'h0100;
    localparam logic [15:0] C_PC_MBR   = 16'h0200;
    localparam logic [15:0] C_ACC_ADD  = 16'h0400;
    localparam logic [15:0] C_ACC_SUB  = 16'h0800;
    localparam logic [15:0] C_ACC_AND  = 16'h1000;
    localparam logic [15:0] C_ACC_OR   = 16'h2000;
    localparam logic [15:0] C_ACC_NOT  = 16'h4000;
    localparam logic [15:0] C_HALT     = 16'h8000;

    localparam logic [OPW-1:0] OP_STORE  = OPW'(8'h01);
    localparam logic [OPW-1:0] OP_LOAD   = OPW'(8'h02);
    localparam logic [OPW-1:0] OP_ADD    = OPW'(8'h03);
    localparam logic [OPW-1:0] OP_SUB    = OPW'(8'h04);
    localparam logic [OPW-1:0] OP_JMPGEZ = OPW'(8'h05);
    localparam logic [OPW-1:0] OP_JMP    = OPW'(8'h06);
    localparam logic [OPW-1:0] OP_HALT   = OPW'(8'h07);
    localparam logic [OPW-1:0] OP_AND    = OPW'(8'h08);
    localparam logic [OPW-1:0] OP_OR     = OPW'(8'h09);
    localparam logic [OPW-1:0] OP_NOT    = OPW'(8'h0A);

    // S_LAUNCH is the single bus-idle cycle between accepting start and the first F0 word
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t         state_q;
    logic [1:0]     step_q;
    logic [HW-1:0]  hold_q;
    logic [OPW-1:0] opcode_q;
    logic [15:0]    cs_q;
    logic           busy_q;
    logic           halted_q;

    function automatic logic [15:0] fetch_word(input logic [1:0] step);
        logic [15:0] w;
        case (step)
            2'd0:    w = C_MAR_PC;
            2'd1:    w = C_MBR_MEM | C_PC_INC;
            default: w = C_IR_MBR | C_MAR_MBR;
        endcase
        return w;
    endfunction

    function automatic logic [15:0] exec_word(input logic [OPW-1:0] op,
                                              input logic [1:0]     step,
                                              input logic           neg);
        logic [15:0] w;
        w = 16'h0000;
        case (op)
            OP_STORE:  w = (step == 2'd0) ? C_MBR_ACC : C_MEM_MBR;
            OP_LOAD:   w = (step == 2'd0) ? C_MBR_MEM :
                           (step == 2'd1) ? (C_BR_MBR | C_ACC_CLR) : C_ACC_ADD;
            OP_ADD:    w = (step == 2'd0) ? C_MBR_MEM :
                           (step == 2'd1) ? C_BR_MBR : C_ACC_ADD;
            OP_SUB:    w = (step == 2'd0) ? C_MBR_MEM :
                           (step == 2'd1) ? C_BR_MBR : C_ACC_SUB;
            OP_JMPGEZ: w = neg ? 16'h0000 : C_PC_MBR;
            OP_JMP:    w = C_PC_MBR;
            OP_HALT:   w = C_HALT;
            OP_AND:    w = (step == 2'd0) ? C_MBR_MEM :
                           (step == 2'd1) ? C_BR_MBR : C_ACC_AND;
            OP_OR:     w = (step == 2'd0) ? C_MBR_MEM :
                           (step == 2'd1) ? C_BR_MBR : C_ACC_OR;
            OP_NOT:    w = C_ACC_NOT;
            default:   w = 16'h0000;
        endcase
        return w;
    endfunction

    function automatic logic [1:0] exec_last(input logic [OPW-1:0] op);
        logic [1:0] n;
        case (op)
            OP_STORE:                                n = 2'd1;
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: n = 2'd2;
            default:                                 n = 2'd0;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            step_q   <= 2'd0;
            hold_q   <= '0;
            opcode_q <= '0;
            cs_q     <= 16'h0000;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_FETCH;
                    step_q  <= 2'd0;
                    hold_q  <= '0;
                    cs_q    <= fetch_word(2'd0);
                    busy_q  <= 1'b1;
                end
                S_FETCH: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_q <= '0;
                        if (step_q == 2'd2) begin
                            // IR has loaded by now; this is the only edge the opcode and sign are used
                            state_q  <= S_EXEC;
                            step_q   <= 2'd0;
                            opcode_q <= ir_opcode;
                            cs_q     <= exec_word(ir_opcode, 2'd0, acc_neg);
                        end else begin
                            step_q <= step_q + 2'd1;
                            cs_q   <= fetch_word(step_q + 2'd1);
                        end
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                S_EXEC: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_q <= '0;
                        if (step_q == exec_last(opcode_q)) begin
                            step_q <= 2'd0;
                            if (opcode_q == OP_HALT) begin
                                state_q  <= S_HALT;
                                cs_q     <= C_HALT;
                                busy_q   <= 1'b0;
                                halted_q <= 1'b1;
                            end else begin
                                state_q <= S_FETCH;
                                cs_q    <= fetch_word(2'd0);
                            end
                        end else begin
                            step_q <= step_q + 2'd1;
                            cs_q   <= exec_word(opcode_q, step_q + 2'd1, 1'b0);
                        end
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                S_HALT: begin
                    cs_q     <= C_HALT;
                    busy_q   <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    cs_q    <= 16'h0000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign control_signals = cs_q;
    assign busy            = busy_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: fetch/execute word sequences, HALT, async reset abort.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  ir_opcode;
    logic        acc_neg;
    logic [15:0] control_signals;
    logic        busy;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    logic [15:0] fetch_seq [6];

    micro_sequencer #(.HOLD_CYCLES(2), .OPW(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .ir_opcode       (ir_opcode),
        .acc_neg         (acc_neg),
        .control_signals (control_signals),
        .busy            (busy),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Pulse start across one rising edge; returns at the negedge right after it
    task automatic launch(input logic [7:0] op, input logic neg);
        ir_opcode = op;
        acc_neg   = neg;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        ir_opcode = 8'h00;
        acc_neg = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (control_signals !== 16'h0000) begin
            failures++;
            $display("FAIL reset_bus: got %h expected 0000", control_signals);
        end
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got busy=%b halted=%b expected 0 0", busy, halted);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (control_signals !== 16'h0000 || busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_no_start[%0d]: got %h busy=%b expected 0000 busy=0", i, control_signals, busy);
            end
        end
    endtask

    task automatic test_fetch_nop();
        logic [15:0] exp_seq [10];
        exp_seq = '{16'h0001, 16'h0001, 16'h0012, 16'h0012, 16'h000C, 16'h000C,
                    16'h0000, 16'h0000, 16'h0001, 16'h0001};
        do_reset();
        launch(8'hFF, 1'b0);
        checks++;
        if (control_signals !== 16'h0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL launch_cycle: got %h busy=%b expected 0000 busy=0", control_signals, busy);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (control_signals !== exp_seq[i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL fetch_nop[%0d]: got %h busy=%b expected %h busy=1", i, control_signals, busy, exp_seq[i]);
            end
        end
    endtask

    task automatic test_load();
        logic [15:0] exp_seq [14];
        exp_seq = '{16'h0001, 16'h0001, 16'h0012, 16'h0012, 16'h000C, 16'h000C,
                    16'h0002, 16'h0002, 16'h0180, 16'h0180, 16'h0400, 16'h0400,
                    16'h0001, 16'h0001};
        do_reset();
        launch(8'h02, 1'b0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            checks++;
            if (control_signals !== exp_seq[i]) begin
                failures++;
                $display("FAIL load[%0d]: got %h expected %h", i, control_signals, exp_seq[i]);
            end
        end
    endtask

    task automatic test_jmpgez();
        logic [15:0] exp_w;
        for (int pass = 0; pass < 2; pass++) begin
            logic neg_final;
            neg_final = (pass == 1);
            exp_w = neg_final ? 16'h0000 : 16'h0200;
            do_reset();
            launch(8'h05, ~neg_final);
            for (int i = 0; i < 10; i++) begin
                logic [15:0] exp_cs;
                @(negedge clk);
                // toggle the sign through F0/F1, settle before F2, disturb again in EXEC
                if (i == 0 || i == 2 || i == 6) acc_neg = ~neg_final;
                if (i == 1 || i == 3) acc_neg = neg_final;
                exp_cs = (i < 6) ? fetch_seq[i] : (i < 8) ? exp_w : 16'h0001;
                checks++;
                if (control_signals !== exp_cs) begin
                    failures++;
                    $display("FAIL jmpgez_neg%0d[%0d]: got %h expected %h", pass, i, control_signals, exp_cs);
                end
            end
        end
    endtask

    task automatic test_opcode_table();
        logic [7:0]  tbl_op  [7];
        int          tbl_len [7];
        logic [15:0] tbl_w   [7][3];
        tbl_op  = '{8'h01, 8'h04, 8'h06, 8'h08, 8'h09, 8'h0A, 8'h00};
        tbl_len = '{2, 3, 1, 3, 3, 1, 1};
        tbl_w   = '{'{16'h0020, 16'h0040, 16'h0000},
                    '{16'h0002, 16'h0080, 16'h0800},
                    '{16'h0200, 16'h0000, 16'h0000},
                    '{16'h0002, 16'h0080, 16'h1000},
                    '{16'h0002, 16'h0080, 16'h2000},
                    '{16'h4000, 16'h0000, 16'h0000},
                    '{16'h0000, 16'h0000, 16'h0000}};
        for (int t = 0; t < 7; t++) begin
            int n;
            n = 6 + 2 * tbl_len[t] + 2;
            do_reset();
            launch(tbl_op[t], 1'b0);
            for (int i = 0; i < n; i++) begin
                logic [15:0] exp_cs;
                @(negedge clk);
                if (i < 6)                          exp_cs = fetch_seq[i];
                else if (i < 6 + 2 * tbl_len[t])    exp_cs = tbl_w[t][(i - 6) / 2];
                else                                exp_cs = 16'h0001;
                checks++;
                if (control_signals !== exp_cs) begin
                    failures++;
                    $display("FAIL op%h[%0d]: got %h expected %h", tbl_op[t], i, control_signals, exp_cs);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_seq [20];
        exp_seq = '{16'h0001, 16'h0001, 16'h0012, 16'h0012, 16'h000C, 16'h000C,
                    16'h0002, 16'h0002, 16'h0080, 16'h0080, 16'h0400, 16'h0400,
                    16'h0001, 16'h0001, 16'h0012, 16'h0012, 16'h000C, 16'h000C,
                    16'h4000, 16'h4000};
        do_reset();
        launch(8'h03, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            // ADD is already latched; the new opcode belongs to the next fetch
            if (i == 6) ir_opcode = 8'h0A;
            checks++;
            if (control_signals !== exp_seq[i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got %h busy=%b expected %h busy=1", i, control_signals, busy, exp_seq[i]);
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        launch(8'h07, 1'b0);
        for (int i = 0; i < 14; i++) begin
            logic [15:0] exp_cs;
            logic        exp_busy;
            logic        exp_halt;
            @(negedge clk);
            if (i == 9)  start = 1'b1;
            if (i == 10) start = 1'b0;
            if (i == 11) ir_opcode = 8'h02;
            exp_cs   = (i < 6) ? fetch_seq[i] : 16'h8000;
            exp_busy = (i < 8);
            exp_halt = (i >= 8);
            checks++;
            if (control_signals !== exp_cs || busy !== exp_busy || halted !== exp_halt) begin
                failures++;
                $display("FAIL halt[%0d]: got %h busy=%b halted=%b expected %h busy=%b halted=%b",
                         i, control_signals, busy, halted, exp_cs, exp_busy, exp_halt);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (control_signals !== 16'h0000 || halted !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL halt_async_reset: got %h busy=%b halted=%b expected 0000 0 0", control_signals, busy, halted);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (control_signals !== 16'h0000 || halted !== 1'b0) begin
                failures++;
                $display("FAIL halt_after_reset[%0d]: got %h halted=%b expected 0000 halted=0", i, control_signals, halted);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        launch(8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++;
        if (control_signals !== 16'h0012) begin
            failures++;
            $display("FAIL abort_precondition: got %h expected 0012", control_signals);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (control_signals !== 16'h0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: got %h busy=%b expected 0000 busy=0", control_signals, busy);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (control_signals !== 16'h0000 || busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_idle[%0d]: got %h busy=%b expected 0000 busy=0", i, control_signals, busy);
            end
        end
        launch(8'hFF, 1'b0);
        @(negedge clk);
        checks++;
        if (control_signals !== 16'h0001 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_f0: got %h busy=%b expected 0001 busy=1", control_signals, busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fetch_seq = '{16'h0001, 16'h0001, 16'h0012, 16'h0012, 16'h000C, 16'h000C};
        test_reset();
        test_fetch_nop();
        test_load();
        test_jmpgez();
        test_opcode_table();
        test_back_to_back();
        test_halt();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
